// File: rtl/uart_pkg.sv
// Shared frame constants and FSM state type for the two-requester UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int   OVERSAMPLE = 16;
    localparam int   DATA_BITS  = 8;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;

endpackage

// File: rtl/uart_rr_arb2.sv
// Two-way round-robin arbiter: picks a winner when enabled; the history bit lives in the caller.
module uart_rr_arb2 (
    input  logic       i_valid0,
    input  logic       i_valid1,
    input  logic       i_last_grant,
    input  logic       i_enable,
    output logic [1:0] o_grant,
    output logic       o_winner
);

    always_comb begin
        o_grant  = 2'b00;
        o_winner = 1'b0;
        if (i_enable) begin
            if (i_valid0 && i_valid1) begin
                // Contention goes to whoever did not win last time.
                o_winner = ~i_last_grant;
                o_grant  = i_last_grant ? 2'b01 : 2'b10;
            end else if (i_valid0) begin
                o_grant = 2'b01;
            end else if (i_valid1) begin
                o_winner = 1'b1;
                o_grant  = 2'b10;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin shared 8N1 UART transmitter for two byte requesters, timed by a 16x baud tick.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE,
    parameter int DATA_BITS  = uart_pkg::DATA_BITS,
    parameter int CNT_W      = 4
) (
    input  logic                 sysclk,
    input  logic                 reset,
    input  logic                 brclk,
    input  logic                 req0_valid,
    input  logic [DATA_BITS-1:0] req0_data,
    output logic                 req0_ack,
    input  logic                 req1_valid,
    input  logic [DATA_BITS-1:0] req1_data,
    output logic                 req1_ack,
    output logic                 txd,
    output logic                 busy,
    output logic                 grant_id,
    output logic                 tx_done
);

    localparam int               IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    state_t               r_state, w_state_next;
    logic [CNT_W-1:0]     r_cnt, w_cnt_next;
    logic [IDX_W-1:0]     r_idx, w_idx_next;
    logic [DATA_BITS-1:0] r_shift, w_shift_next;
    logic                 r_txd, w_txd_next;
    logic                 r_done, w_done_next;
    logic                 r_ack0, r_ack1, r_grant_id, r_last_grant, r_brclk_q;
    logic                 w_tick, w_adv, w_load, w_winner;
    logic [1:0]           w_grant;

    assign w_tick = brclk & ~r_brclk_q;
    assign w_adv  = w_tick && (r_cnt == CNT_LAST);
    assign w_load = |w_grant;

    uart_rr_arb2 u_arb (
        .i_valid0     (req0_valid),
        .i_valid1     (req1_valid),
        .i_last_grant (r_last_grant),
        .i_enable     (r_state == IDLE),
        .o_grant      (w_grant),
        .o_winner     (w_winner)
    );

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_load) w_state_next = START;
            START:   if (w_adv) w_state_next = DATA;
            DATA:    if (w_adv && (r_idx == IDX_LAST)) w_state_next = STOP;
            STOP:    if (w_adv) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_cnt_next   = r_cnt;
        w_idx_next   = r_idx;
        w_shift_next = r_shift;
        w_txd_next   = r_txd;
        w_done_next  = 1'b0;
        if (r_state == IDLE) begin
            // A grant starts the start bit immediately, without waiting for a tick.
            if (w_load) begin
                w_shift_next = w_winner ? req1_data : req0_data;
                w_txd_next   = START_BIT;
                w_cnt_next   = '0;
            end
        end else if (w_tick) begin
            w_cnt_next = w_adv ? '0 : r_cnt + CNT_W'(1);
            if (w_adv) begin
                case (r_state)
                    START: begin
                        w_txd_next = r_shift[0];
                        w_idx_next = '0;
                    end
                    DATA: begin
                        if (r_idx == IDX_LAST) begin
                            w_txd_next = STOP_BIT;
                        end else begin
                            w_shift_next = r_shift >> 1;
                            w_txd_next   = r_shift[1];
                            w_idx_next   = r_idx + IDX_W'(1);
                        end
                    end
                    STOP:    w_done_next = 1'b1;
                    default: w_done_next = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_shift      <= '0;
            r_txd        <= STOP_BIT;
            r_done       <= 1'b0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_grant_id   <= 1'b0;
            r_last_grant <= 1'b1;
            r_brclk_q    <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_next;
            r_idx     <= w_idx_next;
            r_shift   <= w_shift_next;
            r_txd     <= w_txd_next;
            r_done    <= w_done_next;
            r_ack0    <= w_grant[0];
            r_ack1    <= w_grant[1];
            r_brclk_q <= brclk;
            if (w_load) begin
                r_grant_id   <= w_winner;
                r_last_grant <= w_winner;
            end
        end
    end

    assign req0_ack = r_ack0;
    assign req1_ack = r_ack1;
    assign txd      = r_txd;
    assign busy     = (r_state != IDLE);
    assign grant_id = r_grant_id;
    assign tx_done  = r_done;

endmodule
